// File: rtl/cal_trim_ctrl.sv
// Divider trim calibration controller: binary-search trim against a frequency comparator.
// Optional continuous +/-1 tracking while locked is enabled by defining CAL_TRACK_EN.
module cal_trim_ctrl #(
  parameter int TRIM_WIDTH    = 8,
  parameter int TRIM_INIT     = 128,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_ITER      = 64,
  parameter int MEAS_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ref_faster,
  input  logic                  div_faster,
  input  logic                  equal,
  output logic [TRIM_WIDTH-1:0] trim_code,
  output logic                  cnt_clear,
  output logic                  busy,
  output logic                  locked,
  output logic                  cal_error,
  output logic [7:0]            iter_count
);

  // state   | meaning
  // IDLE    | waiting for start
  // CLEAR   | one-cycle counter restart pulse
  // SETTLE  | ignore comparator while counters fill
  // MEASURE | wait for a comparator decision (timeout guarded)
  // ADJUST  | apply step to trim, halve step
  // LOCKED  | trim matched; holds (or tracks by +/-1)
  // FAIL    | bound hit, iteration limit or timeout

  localparam int TMR_MAX = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TRIM_WIDTH-1:0] TRIM_MAX  = '1;
  localparam logic [TRIM_WIDTH-1:0] TRIM_RST  = TRIM_WIDTH'(TRIM_INIT);
  localparam logic [TRIM_WIDTH-1:0] STEP_RST  = TRIM_WIDTH'(1) << (TRIM_WIDTH - 2);
  localparam logic [TMR_W-1:0]      SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]      MEAS_LD   = TMR_W'(MEAS_TIMEOUT - 1);
  localparam logic [8:0]            ITER_LIM  = 9'(MAX_ITER);

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, MEASURE, ADJUST, LOCKED, FAIL} state_t;

  state_t                state;
  logic [TRIM_WIDTH-1:0] step;
  logic [TMR_W-1:0]      tmr;
  logic                  dir_up;

  logic [TRIM_WIDTH:0]   sum_ext;
  logic [TRIM_WIDTH-1:0] trim_up, trim_dn;
  logic [7:0]            iter_next;
  logic                  at_bound, restart;

  always_comb begin
    sum_ext   = {1'b0, trim_code} + {1'b0, step};
    trim_up   = sum_ext[TRIM_WIDTH] ? TRIM_MAX : sum_ext[TRIM_WIDTH-1:0];
    trim_dn   = (trim_code < step) ? '0 : trim_code - step;
    iter_next = iter_count + 8'd1;
    at_bound  = dir_up ? (trim_code == TRIM_MAX) : (trim_code == '0);
    restart   = start && (state == IDLE || state == LOCKED || state == FAIL);
  end

`ifdef CAL_TRACK_EN
  logic                  trk_meas;
  logic [TRIM_WIDTH-1:0] trk_up, trk_dn;

  always_comb begin
    trk_up = (trim_code == TRIM_MAX) ? trim_code : trim_code + TRIM_WIDTH'(1);
    trk_dn = (trim_code == '0) ? trim_code : trim_code - TRIM_WIDTH'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trim_code  <= TRIM_RST;
      step       <= STEP_RST;
      tmr        <= '0;
      dir_up     <= 1'b0;
      iter_count <= '0;
      cnt_clear  <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      cal_error  <= 1'b0;
`ifdef CAL_TRACK_EN
      trk_meas   <= 1'b0;
`endif
    end else begin
      cnt_clear <= 1'b0;
      if (restart) begin
        state      <= CLEAR;
        trim_code  <= TRIM_RST;
        step       <= STEP_RST;
        iter_count <= '0;
        locked     <= 1'b0;
        cal_error  <= 1'b0;
        busy       <= 1'b1;
        cnt_clear  <= 1'b1;
      end else begin
        case (state)
          IDLE, FAIL: ;
          CLEAR: begin
            state <= SETTLE;
            tmr   <= SETTLE_LD;
          end
          SETTLE: begin
            if (tmr == '0) begin
              state <= MEASURE;
              tmr   <= MEAS_LD;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          MEASURE: begin
            if (equal && !ref_faster && !div_faster) begin
              state  <= LOCKED;
              busy   <= 1'b0;
              locked <= 1'b1;
`ifdef CAL_TRACK_EN
              cnt_clear <= 1'b1;
`endif
            end else if (ref_faster ^ div_faster) begin
              dir_up <= ref_faster;
              state  <= ADJUST;
            end else if (tmr == '0) begin
              state     <= FAIL;
              busy      <= 1'b0;
              cal_error <= 1'b1;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          ADJUST: begin
            if (at_bound) begin
              state     <= FAIL;
              busy      <= 1'b0;
              cal_error <= 1'b1;
            end else begin
              trim_code  <= dir_up ? trim_up : trim_dn;
              step       <= (step > TRIM_WIDTH'(1)) ? (step >> 1) : step;
              iter_count <= iter_next;
              if ({1'b0, iter_next} >= ITER_LIM) begin
                state     <= FAIL;
                busy      <= 1'b0;
                cal_error <= 1'b1;
              end else begin
                state     <= CLEAR;
                cnt_clear <= 1'b1;
              end
            end
          end
          LOCKED: begin
`ifdef CAL_TRACK_EN
            // Tracking reuses the settle timer; a pending clear pulse restarts the window.
            if (cnt_clear) begin
              tmr      <= SETTLE_LD;
              trk_meas <= 1'b0;
            end else if (!trk_meas) begin
              if (tmr == '0) trk_meas <= 1'b1;
              else           tmr <= tmr - 1'b1;
            end else if (ref_faster ^ div_faster) begin
              trim_code <= ref_faster ? trk_up : trk_dn;
              cnt_clear <= 1'b1;
            end else if (equal && !ref_faster && !div_faster) begin
              cnt_clear <= 1'b1;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
